midi_note_rx: RTL

//  Serial MIDI receiver and note parser; source of NOTE for note2dds_1st_gen -> DDS -> form_wave.

---
 rtl/midi_note_rx_if.sv | 20 ++
 rtl/midi_note_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/midi_note_rx_if.sv
// NOTE-side bundle of the MIDI receiver: serial line in, note/velocity/gate and strobes out.
// master = receiver (midi_note_rx), slave = line driver / note consumer.
interface midi_note_rx_if;
  logic       midi_rx;
  logic [7:0] note;
  logic [6:0] velocity;
  logic       gate;
  logic       note_stb;
  logic       framing_err;

  modport master (
    input  midi_rx,
    output note, velocity, gate, note_stb, framing_err
  );

  modport slave (
    output midi_rx,
    input  note, velocity, gate, note_stb, framing_err
  );
endinterface

// File: rtl/midi_note_rx.sv
// 8N1 MIDI UART plus Note On/Off parser with running status and last-note priority.
// Define MIDI_OMNI_EN to accept note messages on all 16 channels (CHANNEL then unused).
module midi_note_rx #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 31250,
  parameter logic [3:0]  CHANNEL = 4'd0
) (
  input  logic           clk,
  input  logic           rst_n,
  midi_note_rx_if.master bus
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] FullCnt = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  uart_st_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;

  logic [7:0]      status_q, status_d;
  logic            idx_q, idx_d;
  logic [6:0]      key_q, key_d;
  logic [6:0]      note_q, note_d;
  logic [6:0]      vel_q, vel_d;
  logic            gate_q, gate_d;
  logic            stb_q, stb_d;
  logic            ch_ok;

  // Synchroniser and edge history idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.midi_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only a genuine high-to-low transition starts a byte; a held-low line is ignored.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = StStart;
          cnt_d   = HalfCnt;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d = StData;
            cnt_d   = FullCnt;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FullCnt;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (rx_sync_q) byte_vld_d  = 1'b1;
          else           frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef MIDI_OMNI_EN
  assign ch_ok = 1'b1;
`else
  assign ch_ok = (status_q[3:0] == CHANNEL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      idx_q    <= 1'b0;
      key_q    <= '0;
      note_q   <= 7'd69;
      vel_q    <= '0;
      gate_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      idx_q    <= idx_d;
      key_q    <= key_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      stb_q    <= stb_d;
    end
  end

  // status_q == 0 means no running status (every status byte has bit 7 set).
  always_comb begin
    status_d = status_q;
    idx_d    = idx_q;
    key_d    = key_q;
    note_d   = note_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    stb_d    = 1'b0;
    if (byte_vld_q) begin
      if (shift_q[7:3] == 5'b11111) begin
        // realtime: transparent to the message stream
      end else if (shift_q[7:4] == 4'hF) begin
        status_d = '0;
        idx_d    = 1'b0;
      end else if (shift_q[7]) begin
        status_d = shift_q;
        idx_d    = 1'b0;
      end else if (status_q[7]) begin
        if (!idx_q) begin
          key_d = shift_q[6:0];
          idx_d = 1'b1;
        end else begin
          idx_d = 1'b0;
          if (status_q[7:5] == 3'b100 && ch_ok) begin
            if (status_q[4] && shift_q[6:0] != 7'd0) begin
              note_d = key_q;
              vel_d  = shift_q[6:0];
              gate_d = 1'b1;
              stb_d  = 1'b1;
            end else if (gate_q && key_q == note_q) begin
              gate_d = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.note        = {1'b0, note_q};
  assign bus.velocity    = vel_q;
  assign bus.gate        = gate_q;
  assign bus.note_stb    = stb_q;
  assign bus.framing_err = frame_err_q;

endmodule
